window_7x7_gen: RTL and testbench

- Upstream feeder for neuron_unit.
- Takes a raster-order 8-bit luminance pixel stream, one pixel per cycle qualified by de_in.
- Uses six on-chip line buffers plus a 7x7 shift-register window to present a full 7x7 neighbourhood as seven 56-bit row words, with de_out qualifying each valid window.
- Outputs connect directly to neuron_unit de_in and line_0_in..line_6_in.

---
 rtl/nn_win_pkg.sv | 10 +
 rtl/window_7x7_gen_line_buffer_ram.sv | 23 ++
 rtl/window_7x7_gen.sv | 123 ++++++++++++
 tb/tb_window_7x7_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_win_pkg.sv
// Shared window geometry and pixel/row word types for the 7x7 window generator.
package nn_win_pkg;

  localparam int WIN_SIZE = 7;
  localparam int PIX_W    = 8;

  typedef logic [PIX_W-1:0]          pix_t;
  typedef logic [WIN_SIZE*PIX_W-1:0] win_row_t;

endpackage

// File: rtl/window_7x7_gen_line_buffer_ram.sv
// Single-port line buffer: combinational read of the old word, write on the clock edge,
// so a read and a write to the same address in one cycle return the previous contents.
module line_buffer_ram #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/window_7x7_gen.sv
// Raster pixel stream to 7x7 neighbourhood window generator feeding neuron_unit.
// Optional macro WIN_COUNT_EN adds a saturating 16-bit emitted-window counter (win_cnt).
module window_7x7_gen
  import nn_win_pkg::*;
#(
  parameter int IMG_WIDTH = 28,
  parameter int PIX_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     de_in,
  input  logic                     sof_in,
  input  logic [PIX_W-1:0]         pix_in,
  output logic                     de_out,
  output logic [WIN_SIZE*PIX_W-1:0] line_0_out,
  output logic [WIN_SIZE*PIX_W-1:0] line_1_out,
  output logic [WIN_SIZE*PIX_W-1:0] line_2_out,
  output logic [WIN_SIZE*PIX_W-1:0] line_3_out,
  output logic [WIN_SIZE*PIX_W-1:0] line_4_out,
  output logic [WIN_SIZE*PIX_W-1:0] line_5_out,
  output logic [WIN_SIZE*PIX_W-1:0] line_6_out
`ifdef WIN_COUNT_EN
  ,
  output logic [15:0]              win_cnt
`endif
);

  localparam int AW    = $clog2(IMG_WIDTH);
  localparam int ROW_W = WIN_SIZE * PIX_W;
  localparam int NLB   = WIN_SIZE - 1;

  localparam logic [AW-1:0] COL_LAST = AW'(IMG_WIDTH - 1);
  localparam logic [AW-1:0] COL_MIN  = AW'(WIN_SIZE - 1);
  localparam logic [2:0]    ROW_SAT  = 3'(WIN_SIZE - 1);

  logic [AW-1:0]    col_cnt;
  logic [2:0]       row_cnt;
  logic [AW-1:0]    addr;
  logic [2:0]       row_eff;
  logic             win_valid;
  logic [PIX_W-1:0] lb_rd   [NLB];
  logic [PIX_W-1:0] lb_wr   [NLB];
  logic [PIX_W-1:0] col_vec [WIN_SIZE];
  logic [ROW_W-1:0] win     [WIN_SIZE];

  // A start-of-frame pixel is column 0 / row 0 regardless of where the counters were.
  assign addr      = sof_in ? '0 : col_cnt;
  assign row_eff   = sof_in ? '0 : row_cnt;
  assign win_valid = (row_eff >= ROW_SAT) && (addr >= COL_MIN);

  always_comb begin
    lb_wr[0] = pix_in;
    for (int k = 1; k < NLB; k++) lb_wr[k] = lb_rd[k-1];
    for (int k = 0; k < NLB; k++) col_vec[k] = lb_rd[NLB-1-k];
    col_vec[WIN_SIZE-1] = pix_in;
  end

  for (genvar g = 0; g < NLB; g++) begin : g_lb
    line_buffer_ram #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIX_W)
    ) u_lb (
      .clk     (clk),
      .we      (de_in),
      .addr    (addr),
      .wr_data (lb_wr[g]),
      .rd_data (lb_rd[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (de_in) begin
      if (sof_in) begin
        col_cnt <= AW'(1);
        row_cnt <= '0;
      end else if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        if (row_cnt != ROW_SAT) row_cnt <= row_cnt + 3'd1;
      end else begin
        col_cnt <= col_cnt + AW'(1);
      end
    end
  end

  // The window advances on every accepted pixel, valid or not, so it is primed
  // by the time the first full neighbourhood is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < WIN_SIZE; k++) win[k] <= '0;
      de_out <= 1'b0;
    end else begin
      de_out <= de_in && win_valid;
      if (de_in) begin
        for (int k = 0; k < WIN_SIZE; k++)
          win[k] <= {win[k][ROW_W-PIX_W-1:0], col_vec[k]};
      end
    end
  end

  assign line_0_out = win[0];
  assign line_1_out = win[1];
  assign line_2_out = win[2];
  assign line_3_out = win[3];
  assign line_4_out = win[4];
  assign line_5_out = win[5];
  assign line_6_out = win[6];

`ifdef WIN_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt <= '0;
    end else if (de_in && sof_in) begin
      win_cnt <= '0;
    end else if (de_in && win_valid && (win_cnt != 16'hFFFF)) begin
      win_cnt <= win_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_7x7_gen.sv
// Self-checking bench for window_7x7_gen (IMG_WIDTH=8) against an image-array reference model.
module tb_window_7x7_gen;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_in;
  logic        sof_in;
  logic [7:0]  pix_in;
  logic        de_out;
  logic [55:0] line0, line1, line2, line3, line4, line5, line6;
`ifdef WIN_COUNT_EN
  logic [15:0] win_cnt;
`endif

  always #5 clk = ~clk;

  window_7x7_gen #(
    .IMG_WIDTH (W),
    .PIX_W     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .de_in      (de_in),
    .sof_in     (sof_in),
    .pix_in     (pix_in),
    .de_out     (de_out),
    .line_0_out (line0),
    .line_1_out (line1),
    .line_2_out (line2),
    .line_3_out (line3),
    .line_4_out (line4),
    .line_5_out (line5),
    .line_6_out (line6)
`ifdef WIN_COUNT_EN
    ,
    .win_cnt    (win_cnt)
`endif
  );

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // Reference model: every accepted pixel lands in img at (frame index / W, frame index % W).
  logic [7:0]  img [64][W];
  int          idx;
  logic        expValid;
  logic        haveWin;
  logic [55:0] expLine [7];
  int          expCnt;

  function automatic logic [55:0] getLine(input int k);
    case (k)
      0: return line0;
      1: return line1;
      2: return line2;
      3: return line3;
      4: return line4;
      5: return line5;
      default: return line6;
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("de_out", 56'(de_out), 56'(expValid));
    if (de_out === 1'b1) pulses++;
    if (haveWin) begin
      for (int k = 0; k < 7; k++)
        checkValue($sformatf("line_%0d idx=%0d", k, idx), getLine(k), expLine[k]);
    end
`ifdef WIN_COUNT_EN
    checkValue("win_cnt", 56'(win_cnt), 56'(expCnt));
`endif
  endtask

  task automatic applyStimulus(input logic de, input logic sof, input logic [7:0] pix);
    int r, c;
    de_in  = de;
    sof_in = sof;
    pix_in = pix;
    @(posedge clk);
    #1;
    if (de) begin
      if (sof) begin
        idx = 0;
        expCnt = 0;
      end
      r = idx / W;
      c = idx % W;
      img[r][c] = pix;
      expValid = (r >= 6) && (c >= 6);
      if (expValid) begin
        for (int k = 0; k < 7; k++) begin
          expLine[k] = '0;
          for (int j = 0; j < 7; j++)
            expLine[k] = {expLine[k][47:0], img[r-6+k][c-6+j]};
        end
        if (expCnt != 65535) expCnt++;
      end
      haveWin = expValid;
      idx++;
    end else begin
      expValid = 1'b0;
    end
    de_in  = 1'b0;
    sof_in = 1'b0;
    checkOutput();
  endtask

  task automatic doReset();
    reset  = 1'b1;
    de_in  = 1'b0;
    sof_in = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    idx      = 0;
    expValid = 1'b0;
    haveWin  = 1'b1;
    expCnt   = 0;
    for (int k = 0; k < 7; k++) expLine[k] = '0;
    checkOutput();
  endtask

  // Gap cycles drive random pixel data and a random sof, both of which must be ignored.
  task automatic sendPixel(input logic [7:0] p, input logic s, input int gapPct);
    for (int g = 0; g < 3; g++) begin
      if ($urandom_range(99) < gapPct)
        applyStimulus(1'b0, 1'($urandom_range(1)), 8'($urandom));
    end
    applyStimulus(1'b1, s, p);
  endtask

  task automatic streamPix(input int startIdx, input int nPix, input logic sofFirst,
                           input int gapPct, input logic randomPix, input logic checkConst);
    int r, c;
    logic [7:0] p;
    for (int i = startIdx; i < startIdx + nPix; i++) begin
      r = i / W;
      c = i % W;
      p = randomPix ? 8'($urandom) : {r[3:0], c[3:0]};
      sendPixel(p, sofFirst && (i == startIdx), gapPct);
      if (checkConst && r == 6 && c == 6) begin
        checkValue("first_win_line0", line0, 56'h00010203040506);
        checkValue("first_win_line6", line6, 56'h60616263646566);
      end
      if (checkConst && r == 7 && c == 7) begin
        checkValue("last_win_line0", line0, 56'h11121314151617);
        checkValue("last_win_line6", line6, 56'h71727374757677);
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    de_in  = 1'b0;
    sof_in = 1'b0;
    pix_in = '0;
    doReset();

    $display("[TB] continuous frame");
    pulses = 0;
    streamPix(0, 64, 1'b1, 0, 1'b0, 1'b1);
    checkValue("pulses_frame", 56'(pulses), 56'd4);
`ifdef WIN_COUNT_EN
    checkValue("win_cnt_frame", 56'(win_cnt), 56'd4);
`endif

    $display("[TB] frame with gaps");
    pulses = 0;
    streamPix(0, 64, 1'b1, 30, 1'b0, 1'b1);
    checkValue("pulses_gaps", 56'(pulses), 56'd4);

    $display("[TB] reset mid-frame");
    streamPix(0, 28, 1'b1, 10, 1'b0, 1'b0);
    doReset();
    pulses = 0;
    streamPix(0, 64, 1'b1, 0, 1'b0, 1'b1);
    checkValue("pulses_after_reset", 56'(pulses), 56'd4);

    $display("[TB] sof mid-frame");
    streamPix(0, 60, 1'b1, 0, 1'b0, 1'b0);
    pulses = 0;
    streamPix(0, 54, 1'b1, 0, 1'b0, 1'b0);
    checkValue("pulses_after_sof", 56'(pulses), 56'd0);
    streamPix(54, 10, 1'b0, 0, 1'b0, 1'b1);

    $display("[TB] random pixel frames");
    streamPix(0, 80, 1'b1, 20, 1'b1, 1'b0);
    streamPix(0, 72, 1'b1, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
